uart_frame_arbiter: RTL and testbench

//   Round-robin scheduler that shares one byte-level UART transmitter (TxD_start/TxD_data/TxD_busy

---
 rtl/uart_frame_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
// Round-robin scheduler that shares one byte-level UART transmitter between
// NREQ frame sources. A whole frame is granted at a time. Its bytes are
// streamed through the TxD_start/TxD_busy handshake, and the half-duplex
// driver enable is wrapped in lead and tail guard times.

module uart_frame_arbiter #(
   parameter int NREQ         = 4,
   parameter int ClkFrequency = 12000000,
   parameter int Baud         = 2000000,
   parameter int GUARD_BITS   = 2,
   parameter int TIMEOUT_CYC  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] len,
   input  logic [NREQ*8-1:0] byte_data,
   input  logic [NREQ-1:0]   byte_valid,
   output logic [NREQ-1:0]   byte_ready,
   output logic [NREQ-1:0]   grant,
   output logic              TxD_start,
   output logic [7:0]        TxD_data,
   input  logic              TxD_busy,
   output logic              tx_enable,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int BIT_CYC_RAW = ClkFrequency / Baud;
   localparam int BIT_CYC     = (BIT_CYC_RAW < 1) ? 1 : BIT_CYC_RAW;
   localparam int GUARD_CYC   = GUARD_BITS * BIT_CYC;
   // The tail is never shorter than one cycle, even with zero guard bits.
   localparam int TAIL_CYC    = (GUARD_CYC < 1) ? 1 : GUARD_CYC;
   localparam int GW          = $clog2(TAIL_CYC + 1);
   localparam int TW          = $clog2(TIMEOUT_CYC + 1);
   localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_LOAD,
      S_START,
      S_WAIT,
      S_TAIL
   } state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [7:0]      remaining;
   logic [GW-1:0]   guard_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic            aborted;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic [NREQ-1:0] pick_onehot;
   int              scan_idx;
   logic [7:0]      owner_byte;
   logic            owner_valid;

   // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      pick_found  = 1'b0;
      pick_idx    = '0;
      pick_onehot = '0;
      scan_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
         if (!pick_found && req[scan_idx] && (len[8*scan_idx +: 8] != 8'd0)) begin
            pick_found            = 1'b1;
            pick_idx              = IW'(scan_idx);
            pick_onehot[scan_idx] = 1'b1;
         end
      end
   end

   // The byte lane of the current owner.
   assign owner_byte  = byte_data[8*owner +: 8];
   assign owner_valid = byte_valid[owner];

   // Only the granted requester is offered the byte slot, and only while loading.
   assign byte_ready = (state == S_LOAD) ? grant : '0;

   // Frame sequencer: arbitration, guard times, byte handshake and timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         remaining   <= '0;
         guard_cnt   <= '0;
         tmo_cnt     <= '0;
         aborted     <= 1'b0;
         grant       <= '0;
         TxD_start   <= 1'b0;
         TxD_data    <= '0;
         tx_enable   <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  grant     <= pick_onehot;
                  owner     <= pick_idx;
                  remaining <= len[8*pick_idx +: 8];
                  tx_enable <= 1'b1;
                  guard_cnt <= GW'(GUARD_CYC);
                  aborted   <= 1'b0;
                  state     <= S_LEAD;
               end
            end
            S_LEAD: begin
               // A zero guard still spends exactly one cycle here.
               if (guard_cnt <= GW'(1)) begin
                  tmo_cnt <= '0;
                  state   <= S_LOAD;
               end else begin
                  guard_cnt <= guard_cnt - GW'(1);
               end
            end
            S_LOAD: begin
               if (owner_valid) begin
                  TxD_data  <= owner_byte;
                  TxD_start <= 1'b1;
                  state     <= S_START;
               end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  // Bytes already handed to the transmitter stay sent.
                  frame_abort <= 1'b1;
                  aborted     <= 1'b1;
                  guard_cnt   <= GW'(TAIL_CYC);
                  state       <= S_TAIL;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_START: begin
               if (TxD_busy) begin
                  TxD_start <= 1'b0;
                  remaining <= remaining - 8'd1;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!TxD_busy) begin
                  if (remaining != 8'd0) begin
                     tmo_cnt <= '0;
                     state   <= S_LOAD;
                  end else begin
                     guard_cnt <= GW'(TAIL_CYC);
                     state     <= S_TAIL;
                  end
               end
            end
            S_TAIL: begin
               if (guard_cnt <= GW'(1)) begin
                  tx_enable  <= 1'b0;
                  grant      <= '0;
                  rr_ptr     <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                  frame_done <= !aborted;
                  state      <= S_IDLE;
               end else begin
                  guard_cnt <= guard_cnt - GW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// tb_uart_frame_arbiter
// Randomised scoreboard bench: a frame-level reference model predicts the
// grant order, byte stream and frame endings. A monitor process that also
// emulates the UART transmitter compares the DUT against those predictions.

module tb_uart_frame_arbiter;

   localparam int N       = 4;
   localparam int CLK_HZ  = 12000000;
   localparam int BAUD    = 2000000;
   localparam int GBITS   = 2;
   localparam int TIMEOUT = 1024;
   localparam int GCYC    = GBITS * (CLK_HZ / BAUD);

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*8-1:0] len;
   logic [N*8-1:0] byte_data;
   logic [N-1:0]   byte_valid;
   logic [N-1:0]   byte_ready;
   logic [N-1:0]   grant;
   logic           TxD_start;
   logic [7:0]     TxD_data;
   logic           TxD_busy;
   logic           tx_enable;
   logic           frame_done;
   logic           frame_abort;

   uart_frame_arbiter #(
      .NREQ(N), .ClkFrequency(CLK_HZ), .Baud(BAUD),
      .GUARD_BITS(GBITS), .TIMEOUT_CYC(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .len(len),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .grant(grant), .TxD_start(TxD_start), .TxD_data(TxD_data),
      .TxD_busy(TxD_busy), .tx_enable(tx_enable),
      .frame_done(frame_done), .frame_abort(frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters and check helpers ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
   endtask

   // ---------------- source state ----------------
   logic [7:0] src_bytes [N][8];
   int         src_len   [N];
   int         src_stall [N];
   int         src_reps  [N];
   int         reps_left [N];
   int         ptr       [N];
   bit         active    [N];

   // ---------------- scoreboard ----------------
   typedef struct {
      int owner;
      bit aborted;
   } end_t;

   int         exp_owner_q[$];
   logic [7:0] exp_byte_q[$];
   end_t       exp_end_q[$];
   int         model_rr = 0;

   // Reference model: each pending frame is served in rotation order from the
   // round-robin pointer, which then moves just past the served source.
   task automatic build_expected();
      int   cnt [N];
      int   sent;
      int   pick;
      end_t e;
      for (int i = 0; i < N; i++)
         cnt[i] = (active[i] && src_len[i] != 0) ? src_reps[i] : 0;
      while (1) begin
         pick = -1;
         for (int k = 0; k < N; k++)
            if (pick < 0 && cnt[(model_rr + k) % N] > 0) pick = (model_rr + k) % N;
         if (pick < 0) break;
         sent = (src_stall[pick] < src_len[pick]) ? src_stall[pick] : src_len[pick];
         exp_owner_q.push_back(pick);
         for (int b = 0; b < sent; b++) exp_byte_q.push_back(src_bytes[pick][b]);
         e.owner   = pick;
         e.aborted = (src_stall[pick] < src_len[pick]);
         exp_end_q.push_back(e);
         cnt[pick]--;
         model_rr = (pick + 1) % N;
      end
   endtask

   // ---------------- source driver ----------------
   initial begin
      logic [N-1:0] xfer;
      int           owner_seen;
      owner_seen = 0;
      req        = '0;
      len        = '0;
      byte_data  = '0;
      byte_valid = '0;
      forever begin
         @(negedge clk);
         xfer = byte_ready & byte_valid;
         for (int i = 0; i < N; i++) if (grant[i]) owner_seen = i;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) if (xfer[i]) ptr[i]++;
         if (frame_done || frame_abort) begin
            reps_left[owner_seen]--;
            ptr[owner_seen] = 0;
            if (reps_left[owner_seen] <= 0) active[owner_seen] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            req[i]           = active[i];
            len[8*i +: 8]    = src_len[i][7:0];
            byte_valid[i]    = active[i] && ptr[i] < src_len[i] && ptr[i] < src_stall[i];
            byte_data[8*i +: 8] = (ptr[i] < 8) ? src_bytes[ptr[i] < 8 ? i : 0][ptr[i] & 7] : 8'h00;
         end
      end
   end

   // ---------------- monitor + transmitter model ----------------
   bit           tx_busy;
   int           tx_left;
   int           lead_cnt;
   int           tail_cnt;
   int           aw_cnt;
   int           cap_count = 0;
   int           viol = 0;
   logic [N-1:0] prev_grant;
   logic         prev_txen;

   initial begin
      bit   busy_fell;
      int   eo;
      end_t ee;
      TxD_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            tx_busy = 0; TxD_busy = 1'b0; tx_left = 0;
            lead_cnt = -1; tail_cnt = -1; aw_cnt = -1;
            prev_grant = '0; prev_txen = 1'b0;
            continue;
         end
         if ((byte_ready & ~grant) != '0) viol++;
         if (grant != '0 && (grant & (grant - 1'b1)) != '0) viol++;
         if (prev_grant != '0 && grant != '0 && grant != prev_grant) viol++;

         if (prev_grant == '0 && grant != '0) begin
            if (exp_owner_q.size() == 0) check("grant_unexpected", 32'(grant), 0);
            else begin
               eo = exp_owner_q.pop_front();
               check("grant_owner", 32'(grant), 32'(1) << eo);
               check("grant_txen", 32'(tx_enable), 1);
            end
            lead_cnt = 0;
         end

         busy_fell = 0;
         if (!tx_busy && TxD_start) begin
            cap_count++;
            if (exp_byte_q.size() == 0) check("byte_unexpected", 32'(TxD_data), 32'hFFFF);
            else check("byte_data", 32'(TxD_data), 32'(exp_byte_q.pop_front()));
            if (lead_cnt >= 0) begin
               check_rng("lead_guard", lead_cnt, GCYC, GCYC + 1);
               lead_cnt = -1;
            end
            tx_busy = 1;
            tx_left = $urandom_range(3, 12);
         end else if (tx_busy) begin
            tx_left--;
            if (tx_left == 0) begin
               tx_busy   = 0;
               busy_fell = 1;
            end
         end
         TxD_busy = tx_busy;
         if (lead_cnt >= 0 && tx_enable) lead_cnt++;

         if (busy_fell) begin
            tail_cnt = 0;
            aw_cnt   = 0;
         end else if (aw_cnt >= 0) aw_cnt++;

         if (frame_done || frame_abort) begin
            if (exp_end_q.size() == 0) check("end_unexpected", {frame_abort, frame_done}, 0);
            else begin
               ee = exp_end_q.pop_front();
               check("end_kind", 32'({frame_abort, frame_done}), ee.aborted ? 2 : 1);
               check("end_owner", 32'(prev_grant), 32'(1) << ee.owner);
               if (frame_done) check("done_release", 32'({grant, tx_enable}), 0);
               if (frame_abort && aw_cnt >= 0) check_rng("abort_timeout", aw_cnt, TIMEOUT, TIMEOUT + 1);
            end
            if (frame_abort) tail_cnt = 0;
            aw_cnt = -1;
         end
         if (tail_cnt >= 0 && tx_enable) tail_cnt++;
         if (prev_txen && !tx_enable) begin
            if (tail_cnt >= 0) check_rng("tail_guard", tail_cnt, GCYC, GCYC + 1);
            tail_cnt = -1;
         end
         prev_grant = grant;
         prev_txen  = tx_enable;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_srcs();
      for (int i = 0; i < N; i++) begin
         active[i] = 1'b0; src_len[i] = 0; src_stall[i] = 255; src_reps[i] = 1; ptr[i] = 0;
         for (int b = 0; b < 8; b++) src_bytes[i][b] = 8'($urandom);
      end
   endtask

   task automatic launch();
      for (int i = 0; i < N; i++) begin
         ptr[i] = 0;
         reps_left[i] = src_reps[i];
      end
      build_expected();
   endtask

   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      while ((exp_end_q.size() != 0 || grant != '0 || tx_enable) && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_drained"}, 32'(cyc < 6000), 1);
      check({tag, "_bytes_left"}, 32'(exp_byte_q.size()), 0);
      check({tag, "_invariants"}, 32'(viol), 0);
      for (int i = 0; i < N; i++) active[i] = 1'b0;
      exp_owner_q.delete(); exp_byte_q.delete(); exp_end_q.delete();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int   c0;
      int   cyc;
      int   any;
      rst_n = 1'b0;
      clear_srcs();
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({grant, byte_ready, TxD_start, tx_enable, frame_done, frame_abort}), 0);
      check("reset_txd_data", 32'(TxD_data), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // All four held, one byte each, requester 0 twice: 0,1,2,3,0.
      clear_srcs();
      for (int i = 0; i < N; i++) begin active[i] = 1'b1; src_len[i] = 1; end
      src_reps[0] = 2;
      launch();
      drain("rr_all");

      // Single requester 1 with a three-byte frame.
      clear_srcs();
      active[1] = 1'b1; src_len[1] = 3;
      src_bytes[1][0] = 8'hA1; src_bytes[1][1] = 8'hB2; src_bytes[1][2] = 8'hC3;
      launch();
      drain("single");

      // Zero-length request must never be granted.
      clear_srcs();
      active[2] = 1'b1; src_len[2] = 0;
      active[3] = 1'b1; src_len[3] = 2;
      launch();
      drain("len_zero");

      // Requester 0 stalls after its first byte; requester 1 follows.
      clear_srcs();
      active[0] = 1'b1; src_len[0] = 4; src_stall[0] = 1;
      active[1] = 1'b1; src_len[1] = 2;
      launch();
      drain("abort");

      // Random request mixes.
      for (int r = 0; r < 6; r++) begin
         clear_srcs();
         any = 0;
         for (int i = 0; i < N; i++) begin
            active[i]   = 1'($urandom);
            src_len[i]  = $urandom_range(0, 5);
            src_reps[i] = $urandom_range(1, 2);
            if (active[i] && src_len[i] != 0) any = 1;
         end
         if (any == 0) begin active[r % N] = 1'b1; src_len[r % N] = 2; end
         launch();
         drain("random");
      end

      // Asynchronous reset during the wait for byte 2.
      clear_srcs();
      active[1] = 1'b1; src_len[1] = 3;
      active[2] = 1'b1; src_len[2] = 3;
      launch();
      c0  = cap_count;
      cyc = 0;
      while (cap_count < c0 + 2 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_reached_byte2", 32'(cap_count >= c0 + 2), 1);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_txd_start", 32'(TxD_start), 0);
      check("rst_tx_enable", 32'(tx_enable), 0);
      check("rst_grant", 32'(grant), 0);
      exp_owner_q.delete(); exp_byte_q.delete(); exp_end_q.delete();
      repeat (2) @(negedge clk);
      model_rr = 0;
      launch();
      rst_n = 1'b1;
      drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
